imem_port_ctrl: RTL and testbench
=================================

# imem_port_ctrl

Sequencer and arbiter for the single-port, word-wide ARM instruction memory. After reset it owns the memory for a boot-time program loader. Once the loader signals its last word, it hands the port to the IF stage's fetch unit. From then on, fetch has priority, and late loader writes get bounded-starvation access. It also performs alignment and range checks so the fetch stage never sees undefined data.

## Interface
Parameters:
- DEPTH, 48: memory size in 32-bit words (192 bytes).
- MAX_WAIT, 4: consecutive cycles a pending loader write may be denied in RUN before it is forced through.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address (PC).
- f_gnt  out  1  fetch accepted this cycle.
- f_rvalid  out  1  fetch response valid.
- f_rdata  out  32  instruction word.
- f_err  out  1  response is for a misaligned or out-of-range address.
- l_valid  in  1  loader write valid.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader word.
- l_last  in  1  final boot word.
- l_ready  out  1  loader write accepted when l_valid && l_ready.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  IDX_W  word index = byte address >> 2.
- m_wdata  out  32  write data.
- m_rdata  in  32  read data, valid 1 cycle after m_en && !m_we.
- booted  out  1  high in RUN.

## Operation
- States are BOOT and RUN. Reset enters BOOT.
- **BOOT:**
  - f_gnt = 0 and l_ready = 1.
  - An accepted beat drives m_en = 1, m_we = 1, m_addr = l_addr[IDX_W+1:2] and m_wdata = l_wdata.
  - An accepted beat with l_last = 1 moves the state to RUN on the next edge.
- **RUN:**
  - If f_req and the loader is not forced, f_gnt = 1 and l_ready = 0.
  - Otherwise l_ready = 1 and f_gnt = 0.
  - The loader is forced when l_valid && wait_cnt == MAX_WAIT.
  - l_last is ignored in RUN.
- **wait_cnt:**
  - Increments when l_valid && f_req && !l_ready in RUN, saturating at MAX_WAIT.
  - Clears when a loader beat is accepted or l_valid = 0.
- **Address check:** bad = addr[1:0] != 0 || (addr >> 2) >= DEPTH.
  - Bad fetch: granted normally with m_en = 0. The response is f_rvalid = 1, f_err = 1, f_rdata = 0.
  - Bad loader write: accepted (l_ready as usual) with m_en = 0. It is silently dropped.
- **Good fetch:** m_en = 1, m_we = 0. The response is f_rvalid = 1, f_err = 0, f_rdata = m_rdata.
- f_rdata = 0 whenever f_rvalid = 0 or f_err = 1.
- At most one memory operation per cycle. A read of a word written in an earlier cycle returns the new data.
- Memory contents survive rst. Reset returns to BOOT, so the loader must reload, or assert a single l_last beat to an out-of-range address to skip.

## Timing
- While rst = 1: f_gnt, l_ready, m_en, m_we, f_rvalid, f_err, booted are 0; f_rdata = 0; m_addr and m_wdata are 0.
- First cycle after rst falls: BOOT, l_ready = 1.
- f_gnt, l_ready, m_* are combinational from state, wait_cnt and inputs in the same cycle.
- Fetch latency: grant in cycle t gives f_rvalid in cycle t+1, one cycle wide. Back-to-back grants produce back-to-back responses, for one fetch per cycle throughput.
- f_rvalid and f_err are registered. A grant in the cycle rst rises produces no response.
- BOOT to RUN: a beat with l_last accepted in cycle t makes booted = 1 and allows f_gnt in cycle t+1.
- Worst-case loader wait in RUN is MAX_WAIT cycles, accepted on cycle MAX_WAIT+1. The fetch unit sees exactly one f_gnt = 0 cycle per forced write.

## Structure
- Package imem_pkg holds:
  - state enum {BOOT, RUN};
  - IDX_W = $clog2(DEPTH);
  - a function for word index extraction.
- Sub-module imem_addr_check (combinational: byte address to index plus bad flag) is instantiated twice, for fetch and loader.
- The memory array itself is external.

## Test plan
- **Boot load:** write words 0..47 with l_last on index 47, f_req held high. Required: f_gnt = 0 throughout, booted = 1 the cycle after the last beat, and fetch of address 0x00 returns word 0 one cycle after grant.
- **Streaming fetch:** f_req every cycle with addresses 0x00, 0x04, 0x08. Required: f_rvalid = 1 on three consecutive cycles with matching words and f_err = 0.
- **Bad addresses:** fetch of 0x02, then fetch of 0xC0 (index 48). Required: both granted, f_rvalid = 1, f_err = 1, f_rdata = 0, m_en = 0. A loader write to 0xC0 is accepted but m_en = 0.
- **Starvation:** RUN, f_req continuously high, l_valid high to address 0x10 with data 0xDEADBEEF, MAX_WAIT = 4. Required: l_ready = 0 for 4 cycles, l_ready = 1 and f_gnt = 0 on the 5th, and a subsequent fetch of 0x10 returns 0xDEADBEEF.
- **Reset mid-operation:** rst asserted in the cycle a fetch is granted in RUN. Required: no f_rvalid next cycle, booted = 0, l_ready = 1 after rst falls, and memory contents preserved (single l_last skip beat, then fetch of 0x00 returns the old word).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port controller.
// IDX_W is the word-index width for the default 48-word memory.
package imem_pkg;

    localparam int DEPTH_DEF = 48;
    localparam int IDX_W     = $clog2(DEPTH_DEF);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Byte address to word address; callers slice off the index bits they need.
    function automatic logic [29:0] word_of(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Byte address to word index, flagging misaligned or out-of-range addresses.
// Used once for the fetch address and once for the loader address.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = IDX_W
) (
    input  logic [31:0]   addr_i,
    output logic [IW-1:0] idx_o,
    output logic          bad_o
);

    logic [29:0] word;

    assign word  = word_of(addr_i);
    assign idx_o = word[IW-1:0];
    assign bad_o = (addr_i[1:0] != 2'b00) || (word >= 30'(DEPTH));

endmodule

// File: rtl/imem_port_ctrl.sv
// Boot-loader / fetch arbiter for the single-port instruction memory.
// Loader owns the port until its last word; then fetch wins, with bounded loader starvation.
//
//   state | meaning
//   BOOT  | loader owns the port, fetch is never granted
//   RUN   | fetch has priority; a loader write denied MAX_WAIT cycles is forced through
module imem_port_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     f_req_i,
    input  logic [31:0]              f_addr_i,
    output logic                     f_gnt_o,
    output logic                     f_rvalid_o,
    output logic [31:0]              f_rdata_o,
    output logic                     f_err_o,
    input  logic                     l_valid_i,
    input  logic [31:0]              l_addr_i,
    input  logic [31:0]              l_wdata_i,
    input  logic                     l_last_i,
    output logic                     l_ready_o,
    output logic                     m_en_o,
    output logic                     m_we_o,
    output logic [$clog2(DEPTH)-1:0] m_addr_o,
    output logic [31:0]              m_wdata_o,
    input  logic [31:0]              m_rdata_i,
    output logic                     booted_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rvalid_q, err_q;

    logic [AW-1:0] f_idx, l_idx;
    logic          f_bad, l_bad;
    logic          forced, l_acc;

    imem_addr_check #(.DEPTH(DEPTH), .IW(AW)) u_f_chk (
        .addr_i (f_addr_i),
        .idx_o  (f_idx),
        .bad_o  (f_bad)
    );

    imem_addr_check #(.DEPTH(DEPTH), .IW(AW)) u_l_chk (
        .addr_i (l_addr_i),
        .idx_o  (l_idx),
        .bad_o  (l_bad)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        forced    = 1'b0;
        l_acc     = 1'b0;
        f_gnt_o   = 1'b0;
        l_ready_o = 1'b0;
        m_en_o    = 1'b0;
        m_we_o    = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                BOOT: l_ready_o = 1'b1;
                RUN: begin
                    forced = l_valid_i && (wait_q == WAIT_MAX);
                    if (f_req_i && !forced) begin
                        f_gnt_o = 1'b1;
                    end else begin
                        l_ready_o = 1'b1;
                    end
                end
                default: l_ready_o = 1'b1;
            endcase

            l_acc = l_valid_i && l_ready_o;

            // Bad addresses still complete the handshake but never touch the array.
            if (f_gnt_o && !f_bad) begin
                m_en_o   = 1'b1;
                m_addr_o = f_idx;
            end else if (l_acc && !l_bad) begin
                m_en_o    = 1'b1;
                m_we_o    = 1'b1;
                m_addr_o  = l_idx;
                m_wdata_o = l_wdata_i;
            end

            if (state_q == BOOT && l_acc && l_last_i) begin
                state_d = RUN;
            end

            if (l_acc || !l_valid_i) begin
                wait_d = '0;
            end else if (state_q == RUN && f_req_i && wait_q != WAIT_MAX) begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= BOOT;
            wait_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= f_gnt_o;
            err_q    <= f_gnt_o && f_bad;
        end
    end

    assign f_rvalid_o = rvalid_q && !rst_i;
    assign f_err_o    = err_q && !rst_i;
    assign f_rdata_o  = (f_rvalid_o && !f_err_o) ? m_rdata_i : 32'h0;
    assign booted_o   = (state_q == RUN) && !rst_i;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Bench for imem_port_ctrl: directed boot/fetch/starvation/reset steps then random traffic,
// checked every cycle against a behavioural model of the arbitration rules and memory contents.
module tb_imem_port_ctrl;

    localparam int DEPTH = 48;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        l_valid = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        l_last = 1'b0;
    logic        l_ready, m_en, m_we, booted;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    imem_port_ctrl #(.DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .f_req_i    (f_req),
        .f_addr_i   (f_addr),
        .f_gnt_o    (f_gnt),
        .f_rvalid_o (f_rvalid),
        .f_rdata_o  (f_rdata),
        .f_err_o    (f_err),
        .l_valid_i  (l_valid),
        .l_addr_i   (l_addr),
        .l_wdata_i  (l_wdata),
        .l_last_i   (l_last),
        .l_ready_o  (l_ready),
        .m_en_o     (m_en),
        .m_we_o     (m_we),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_rdata_i  (m_rdata),
        .booted_o   (booted)
    );

    // External single-port memory; not reset, so contents survive rst.
    logic [31:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) env_mem[m_addr] <= m_wdata;
            else      m_rdata <= env_mem[m_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          mb;
    int          den;
    bit          e_rv, e_err;
    logic [31:0] e_rd;

    int npass  = 0;
    int ntotal = 0;

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input bit r, input bit fq, input logic [31:0] fa,
                       input bit lv, input logic [31:0] la, input logic [31:0] ld,
                       input bit ll);
        bit fg, lr, me, we, fb, lb;
        @(negedge clk);
        rst = r; f_req = fq; f_addr = fa;
        l_valid = lv; l_addr = la; l_wdata = ld; l_last = ll;
        #1;
        fb = bad(fa);
        lb = bad(la);
        if (r) begin
            fg = 0; lr = 0; me = 0; we = 0;
        end else begin
            if (!mb) begin
                fg = 0; lr = 1;
            end else begin
                fg = fq && !(lv && den >= MAXW);
                lr = !fg;
            end
            me = fg ? !fb : (lv && lr && !lb);
            we = me && !fg;
        end
        chk("f_gnt", 32'(f_gnt), 32'(fg));
        chk("l_ready", 32'(l_ready), 32'(lr));
        chk("m_en", 32'(m_en), 32'(me));
        chk("m_we", 32'(m_we), 32'(we));
        chk("booted", 32'(booted), 32'(!r && mb));
        chk("f_rvalid", 32'(f_rvalid), 32'(!r && e_rv));
        chk("f_err", 32'(f_err), 32'(!r && e_err));
        chk("f_rdata", f_rdata, (!r && e_rv && !e_err) ? e_rd : 32'h0);
        if (me) chk("m_addr", 32'(m_addr), fg ? (fa >> 2) : (la >> 2));
        if (we) chk("m_wdata", m_wdata, ld);
        if (r) begin
            chk("m_addr_rst", 32'(m_addr), 32'h0);
            chk("m_wdata_rst", m_wdata, 32'h0);
        end
        @(posedge clk);
        if (r) begin
            mb = 0; den = 0; e_rv = 0; e_err = 0;
        end else begin
            e_rv  = fg;
            e_err = fg && fb;
            if (fg && !fb) e_rd = ref_mem[fa >> 2];
            if (lv && lr && !lb) ref_mem[la >> 2] = ld;
            if (!mb && lv && lr && ll) mb = 1;
            den = (lv && !lr) ? ((den + 1 > MAXW) ? MAXW : den + 1) : 0;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 9) < 9) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        return $urandom & 32'h0000_00ff;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        mb = 0; den = 0; e_rv = 0; e_err = 0; e_rd = '0;

        cyc(1, 1, 32'h0, 0, 32'h0, 32'h0, 0);
        cyc(1, 1, 32'h0, 0, 32'h0, 32'h0, 0);

        // Boot load of every word with fetch requesting throughout.
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 1, 32'h0, 1, 32'(i) << 2, $urandom, i == DEPTH - 1);

        // Streaming fetch.
        cyc(0, 1, 32'h00, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, 32'h04, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, 32'h08, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h00, 0, 32'h0, 32'h0, 0);

        // Misaligned and out-of-range accesses.
        cyc(0, 1, 32'h02, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, 32'hC0, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h00, 1, 32'hC0, 32'h1234_5678, 0);
        cyc(0, 0, 32'h00, 0, 32'h0, 32'h0, 0);

        // Loader starved by continuous fetch, then forced through.
        for (int i = 0; i < MAXW + 1; i++)
            cyc(0, 1, 32'(i) << 2, 1, 32'h10, 32'hDEAD_BEEF, 0);
        cyc(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h00, 0, 32'h0, 32'h0, 0);

        // Reset in the same cycle as a fetch request, then skip-boot and re-fetch.
        cyc(1, 1, 32'h00, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h00, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, 32'h00, 1, 32'hC0, 32'h0, 1);
        cyc(0, 1, 32'h00, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 32'h00, 0, 32'h0, 32'h0, 0);

        // Random traffic, including occasional resets and late loader writes.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rnd_addr(),
                $urandom_range(0, 9) < 4, rnd_addr(), $urandom, $urandom_range(0, 9) == 0);
        cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
